// File: rtl/spi_slave_9952.sv
// ============================================================================
//  Module     : spi_slave_9952
//  Description: AD9952-style 3-wire SPI responder. It decodes the instruction
//               byte, fills shadow registers, and copies shadow to active on
//               io_update. All pins are oversampled in the clk domain.
//               Optional feature macro: SPI_9952_RDBACK_EN. When it is
//               defined, readback is driven on sdio.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module spi_slave_9952 #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        n_cs,
   input  logic        sclk,
   inout  wire         sdio,
   input  logic        io_update,
   output logic [31:0] cfr1,
   output logic [23:0] cfr2,
   output logic [15:0] asf,
   output logic [7:0]  arr,
   output logic [31:0] ftw,
   output logic [15:0] pow,
   output logic        upd_strobe,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_INSTR = 3'd1,
      S_WDATA = 3'd2,
      S_RDATA = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // ---------------------------------------------------------------------
   // Pin synchronisers and edge detection
   // ---------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] sdio_sync_q;
   logic [SYNC_STAGES-1:0] upd_sync_q;
   logic                   sclk_prev_q;
   logic                   upd_prev_q;

   logic w_cs_n_s;
   logic w_sclk_s;
   logic w_sdio_s;
   logic w_upd_s;
   logic w_sclk_rise;
   logic w_upd_rise;

   // Shift every pin through its synchroniser chain and keep the previous sample for edge detection
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cs_sync_q   <= '1;
         sclk_sync_q <= '0;
         sdio_sync_q <= '0;
         upd_sync_q  <= '0;
         sclk_prev_q <= 1'b0;
         upd_prev_q  <= 1'b0;
      end else begin
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], n_cs};
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
         sdio_sync_q <= {sdio_sync_q[SYNC_STAGES-2:0], sdio};
         upd_sync_q  <= {upd_sync_q[SYNC_STAGES-2:0], io_update};
         sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
         upd_prev_q  <= upd_sync_q[SYNC_STAGES-1];
      end
   end

   assign w_cs_n_s    = cs_sync_q[SYNC_STAGES-1];
   assign w_sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign w_sdio_s    = sdio_sync_q[SYNC_STAGES-1];
   assign w_upd_s     = upd_sync_q[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk_s & ~sclk_prev_q;
   assign w_upd_rise  = w_upd_s & ~upd_prev_q;

   // ---------------------------------------------------------------------
   // Register map helpers
   // ---------------------------------------------------------------------
   function automatic logic [2:0] reg_len(input logic [4:0] a);
      case (a)
         5'h00:   reg_len = 3'd4;
         5'h01:   reg_len = 3'd3;
         5'h02:   reg_len = 3'd2;
         5'h03:   reg_len = 3'd1;
         5'h04:   reg_len = 3'd4;
         5'h05:   reg_len = 3'd2;
         default: reg_len = 3'd1;   // invalid addresses still consume one byte
      endcase
   endfunction

   function automatic logic addr_ok(input logic [4:0] a);
      addr_ok = (a <= 5'h05);
   endfunction

   // ---------------------------------------------------------------------
   // Frame state
   // ---------------------------------------------------------------------
   state_t      state_q;
   logic [5:0]  bit_cnt_q;
   logic        rw_q;
   logic [4:0]  addr_q;
   logic [31:0] wsr_q;
   logic        wr_stb_q;
   logic        err_q;

   logic [4:0]  w_addr_dec;
   logic [5:0]  w_last_idx;

   // Address as it stands once the 8th instruction bit is shifted in
   assign w_addr_dec = {addr_q[3:0], w_sdio_s};
   assign w_last_idx = {reg_len(addr_q), 3'b000} - 6'd1;

   // Shadow and active registers
   logic [31:0] sh_cfr1_q, sh_cfr1_d, act_cfr1_q;
   logic [23:0] sh_cfr2_q, sh_cfr2_d, act_cfr2_q;
   logic [15:0] sh_asf_q,  sh_asf_d,  act_asf_q;
   logic [7:0]  sh_arr_q,  sh_arr_d,  act_arr_q;
   logic [31:0] sh_ftw_q,  sh_ftw_d,  act_ftw_q;
   logic [15:0] sh_pow_q,  sh_pow_d,  act_pow_q;
   logic        upd_strobe_q;

`ifdef SPI_9952_RDBACK_EN
   logic [31:0] rsr_q;
   logic        rd_oe_q;
   logic [31:0] w_rd_word;
   logic        w_sclk_fall;

   assign w_sclk_fall = ~w_sclk_s & sclk_prev_q;

   // Left-align the addressed shadow word so the MSB of the register leaves first
   always_comb begin
      w_rd_word = '0;
      case (w_addr_dec)
         5'h00:   w_rd_word = sh_cfr1_q;
         5'h01:   w_rd_word = {sh_cfr2_q, 8'h00};
         5'h02:   w_rd_word = {sh_asf_q, 16'h0000};
         5'h03:   w_rd_word = {sh_arr_q, 24'h000000};
         5'h04:   w_rd_word = sh_ftw_q;
         5'h05:   w_rd_word = {sh_pow_q, 16'h0000};
         default: w_rd_word = '0;
      endcase
   end

   assign sdio = rd_oe_q ? rsr_q[31] : 1'bz;
`else
   assign sdio = 1'bz;
`endif

   // Frame sequencer: instruction decode, data shifting, abort and error tracking
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         rw_q      <= 1'b0;
         addr_q    <= '0;
         wsr_q     <= '0;
         wr_stb_q  <= 1'b0;
         err_q     <= 1'b0;
`ifdef SPI_9952_RDBACK_EN
         rsr_q     <= '0;
         rd_oe_q   <= 1'b0;
`endif
      end else begin
         wr_stb_q <= 1'b0;
         if (w_cs_n_s) begin
            // Chip select released: any frame not yet complete is an abort
            if ((state_q == S_INSTR && bit_cnt_q != 6'd0) ||
                state_q == S_WDATA || state_q == S_RDATA) begin
               err_q <= 1'b1;
            end
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
`ifdef SPI_9952_RDBACK_EN
            rd_oe_q   <= 1'b0;
`endif
         end else begin
            case (state_q)
               S_IDLE: begin
                  state_q   <= S_INSTR;
                  bit_cnt_q <= '0;
               end
               S_INSTR: begin
                  if (w_sclk_rise) begin
                     addr_q <= w_addr_dec;
                     if (bit_cnt_q == 6'd0) begin
                        rw_q <= w_sdio_s;
                     end
                     if (bit_cnt_q == 6'd7) begin
                        bit_cnt_q <= '0;
                        if (!addr_ok(w_addr_dec)) begin
                           err_q <= 1'b1;
                        end
                        if (rw_q) begin
                           state_q <= S_RDATA;
`ifdef SPI_9952_RDBACK_EN
                           rsr_q   <= w_rd_word;
`endif
                        end else begin
                           state_q <= S_WDATA;
                        end
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 6'd1;
                     end
                  end
               end
               S_WDATA: begin
                  if (w_sclk_rise) begin
                     wsr_q <= {wsr_q[30:0], w_sdio_s};
                     if (bit_cnt_q == w_last_idx) begin
                        state_q  <= S_DONE;
                        wr_stb_q <= addr_ok(addr_q);
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 6'd1;
                     end
                  end
               end
               S_RDATA: begin
                  if (w_sclk_rise) begin
                     if (bit_cnt_q == w_last_idx) begin
                        state_q <= S_DONE;
`ifdef SPI_9952_RDBACK_EN
                        rd_oe_q <= 1'b0;
`endif
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 6'd1;
                     end
                  end
`ifdef SPI_9952_RDBACK_EN
                  // First fall enables the driver with the MSB; later falls advance the word
                  if (w_sclk_fall) begin
                     if (!rd_oe_q) begin
                        rd_oe_q <= 1'b1;
                     end else begin
                        rsr_q <= {rsr_q[30:0], 1'b0};
                     end
                  end
`endif
               end
               S_DONE: begin
                  state_q <= S_DONE;
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   // Next shadow contents: a completed write frame lands as a whole word
   always_comb begin
      sh_cfr1_d = sh_cfr1_q;
      sh_cfr2_d = sh_cfr2_q;
      sh_asf_d  = sh_asf_q;
      sh_arr_d  = sh_arr_q;
      sh_ftw_d  = sh_ftw_q;
      sh_pow_d  = sh_pow_q;
      if (wr_stb_q) begin
         case (addr_q)
            5'h00:   sh_cfr1_d = wsr_q;
            5'h01:   sh_cfr2_d = wsr_q[23:0];
            5'h02:   sh_asf_d  = wsr_q[15:0];
            5'h03:   sh_arr_d  = wsr_q[7:0];
            5'h04:   sh_ftw_d  = wsr_q;
            5'h05:   sh_pow_d  = wsr_q[15:0];
            default: ;
         endcase
      end
   end

   // Shadow update and io_update transfer; the transfer uses next-shadow so a same-clock write wins
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sh_cfr1_q    <= '0;
         sh_cfr2_q    <= '0;
         sh_asf_q     <= '0;
         sh_arr_q     <= '0;
         sh_ftw_q     <= '0;
         sh_pow_q     <= '0;
         act_cfr1_q   <= '0;
         act_cfr2_q   <= '0;
         act_asf_q    <= '0;
         act_arr_q    <= '0;
         act_ftw_q    <= '0;
         act_pow_q    <= '0;
         upd_strobe_q <= 1'b0;
      end else begin
         sh_cfr1_q    <= sh_cfr1_d;
         sh_cfr2_q    <= sh_cfr2_d;
         sh_asf_q     <= sh_asf_d;
         sh_arr_q     <= sh_arr_d;
         sh_ftw_q     <= sh_ftw_d;
         sh_pow_q     <= sh_pow_d;
         upd_strobe_q <= w_upd_rise;
         if (w_upd_rise) begin
            act_cfr1_q <= sh_cfr1_d;
            act_cfr2_q <= sh_cfr2_d;
            act_asf_q  <= sh_asf_d;
            act_arr_q  <= sh_arr_d;
            act_ftw_q  <= sh_ftw_d;
            act_pow_q  <= sh_pow_d;
         end
      end
   end

   assign cfr1       = act_cfr1_q;
   assign cfr2       = act_cfr2_q;
   assign asf        = act_asf_q;
   assign arr        = act_arr_q;
   assign ftw        = act_ftw_q;
   assign pow        = act_pow_q;
   assign upd_strobe = upd_strobe_q;
   assign err        = err_q;

endmodule

`default_nettype wire
